// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver that oversamples the pins on the system clock. It decodes 11-bit odd-parity
// frames and queues good bytes in a first-word-fall-through FIFO with a valid/ready read port.
module ps2_rx_fifo #(
    parameter int DATA_BITS      = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    localparam int CW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DATA_BITS-1:0] out_data,
    output logic [CW-1:0]        fifo_count,
    output logic                 err_parity,
    output logic                 err_frame,
    output logic                 err_ovf,
    output logic [1:0]           fsm_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   sync_clk;
    logic                   sync_data;
    logic                   prev_sync_clk;
    logic                   fall;

    state_t                 state;
    logic [BW-1:0]          bitcnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   parity_bit;
    logic [TW-1:0]          tmo_cnt;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count;

    logic push_ok;
    logic pop;
    logic full;
    logic do_push;
    logic ovf;

    assign sync_clk  = clk_sync[SYNC_STAGES-1];
    assign sync_data = data_sync[SYNC_STAGES-1];
    assign fsm_state = state;

    // Pins idle high, so the chains reset to 1 to avoid a false fall on release.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            clk_sync      <= '1;
            data_sync     <= '1;
            prev_sync_clk <= 1'b1;
            fall          <= 1'b0;
        end else begin
            clk_sync      <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync     <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            prev_sync_clk <= sync_clk;
            fall          <= prev_sync_clk & ~sync_clk;
        end
    end

    assign push_ok = en && fall && (state == STOP) && sync_data && (^{shreg, parity_bit});

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            tmo_cnt    <= '0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            if (!en) begin
                state   <= IDLE;
                bitcnt  <= '0;
                tmo_cnt <= '0;
            end else if (fall) begin
                tmo_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!sync_data) begin
                            state  <= DATA;
                            bitcnt <= '0;
                            shreg  <= '0;
                        end
                    end
                    DATA: begin
                        shreg  <= {sync_data, shreg[DATA_BITS-1:1]};
                        bitcnt <= bitcnt + BW'(1);
                        if (bitcnt == BW'(DATA_BITS - 1)) state <= PARITY;
                    end
                    PARITY: begin
                        parity_bit <= sync_data;
                        state      <= STOP;
                    end
                    STOP: begin
                        // Parity is judged first so a frame never raises both errors.
                        if (!(^{shreg, parity_bit})) err_parity <= 1'b1;
                        else if (!sync_data)         err_frame  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                err_frame <= 1'b1;
                state     <= IDLE;
                bitcnt    <= '0;
                tmo_cnt   <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    // Read port: a byte transfers on every CLK edge where out_valid and out_ready are both 1;
    // out_valid never depends on out_ready, and out_data is stable while out_valid waits.
    assign full      = (count == CW'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign do_push   = push_ok & (~full | pop);
    assign ovf       = push_ok & full & ~pop;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_ovf <= 1'b0;
        end else begin
            err_ovf <= ovf;
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: good, bad-parity, bad-stop and timed-out frames, FIFO
// overflow and simultaneous push/pop, mid-frame reset and an idle glitch.
module tb_ps2_rx_fifo;
    localparam int DATA_BITS = 8;
    localparam int DEPTH     = 4;
    localparam int TIMEOUT   = 200;
    localparam int HALF      = 20;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic                 clk;
    logic                 rst_n;
    logic                 en;
    logic                 ps2_clk;
    logic                 ps2_data;
    logic                 out_ready;
    logic                 out_valid;
    logic [DATA_BITS-1:0] out_data;
    logic [CW-1:0]        fifo_count;
    logic                 err_parity;
    logic                 err_frame;
    logic                 err_ovf;
    logic [1:0]           fsm_state;

    int checks = 0;
    int errors = 0;
    int n_par  = 0;
    int n_frm  = 0;
    int n_ovf  = 0;
    logic [DATA_BITS-1:0] exp_q[$];

    ps2_rx_fifo #(
        .DATA_BITS(DATA_BITS), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLK(clk), .reset(rst_n), .en(en), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .fifo_count(fifo_count), .err_parity(err_parity), .err_frame(err_frame),
        .err_ovf(err_ovf), .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_parity) n_par++;
        if (err_frame)  n_frm++;
        if (err_ovf)    n_ovf++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives nfalls bits of a frame; parity is odd unless flipped. With pop_on_stop,
    // out_ready is raised for exactly the cycle in which the stop fall pushes.
    task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_bit,
                              input bit pop_on_stop, input int nfalls);
        logic [10:0] bits;
        bits = {stop_bit, (~^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < nfalls; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (pop_on_stop && i == 10) begin
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                repeat (HALF - 4) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        logic [DATA_BITS-1:0] e;
        e = exp_q.pop_front();
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(e));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; out_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_errs", 32'({err_parity, err_frame, err_ovf}), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rel_errs", 32'({err_parity, err_frame, err_ovf}), 0);

        // good frame 0x1C
        send_frame(8'h1C, 0, 1, 0, 11);
        exp_q.push_back(8'h1C);
        check("t1_count", 32'(fifo_count), 1);
        check("t1_errs", 32'(n_par + n_frm + n_ovf), 0);
        pop_check("t1_pop");
        check("t1_empty", 32'(out_valid), 0);

        // bad parity, then bad stop
        send_frame(8'h1C, 1, 1, 0, 11);
        check("t2_par_pulses", 32'(n_par), 1);
        check("t2_count", 32'(fifo_count), 0);
        send_frame(8'h55, 0, 0, 0, 11);
        check("t2_frm_pulses", 32'(n_frm), 1);
        check("t2_par_unchanged", 32'(n_par), 1);
        check("t2_count_b", 32'(fifo_count), 0);

        // timeout after three falls, then a good frame
        send_frame(8'hA5, 0, 1, 0, 3);
        repeat (TIMEOUT + 50) @(negedge clk);
        check("t3_frm_pulses", 32'(n_frm), 2);
        check("t3_idle", 32'(fsm_state), 0);
        send_frame(8'hF0, 0, 1, 0, 11);
        exp_q.push_back(8'hF0);
        pop_check("t3_pop");

        // overflow on the fifth byte
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 0, 1, 0, 11);
            if (i <= DEPTH) exp_q.push_back(8'(i));
        end
        check("t4_count", 32'(fifo_count), DEPTH);
        check("t4_ovf_pulses", 32'(n_ovf), 1);
        for (int i = 0; i < DEPTH; i++) pop_check("t4_pop");
        @(negedge clk);
        check("t4_empty", 32'(out_valid), 0);
        check("t4_count0", 32'(fifo_count), 0);

        // full FIFO, push and pop in the same cycle
        for (int i = 1; i <= DEPTH; i++) begin
            send_frame(8'(i), 0, 1, 0, 11);
            exp_q.push_back(8'(i));
        end
        send_frame(8'h66, 0, 1, 1, 11);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h66);
        check("t5_count", 32'(fifo_count), DEPTH);
        check("t5_ovf_pulses", 32'(n_ovf), 1);
        for (int i = 0; i < DEPTH; i++) pop_check("t5_pop");
        @(negedge clk);
        check("t5_empty", 32'(out_valid), 0);

        // reset after data bit 4, then 0x29
        send_frame(8'hC3, 0, 1, 0, 6);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_idle", 32'(fsm_state), 0);
        send_frame(8'h29, 0, 1, 0, 11);
        exp_q.push_back(8'h29);
        check("t6_count", 32'(fifo_count), 1);
        pop_check("t6_pop");
        @(negedge clk);
        check("t6_empty", 32'(out_valid), 0);

        // glitch fall with data high while idle
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        check("glitch_idle", 32'(fsm_state), 0);
        check("glitch_count", 32'(fifo_count), 0);
        check("err_totals", 32'({8'(n_par), 8'(n_frm), 8'(n_ovf)}), 32'h00010201);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
